// File: rtl/seg_pkg.sv
// Shared seven-segment constants and formatter state encoding.
// Bit order {a,b,c,d,e,f,g,dp}, active-high.
package seg_pkg;

  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
    8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
  };

  localparam int MAX_DISPLAY = 99_999_999;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    ENCODE
  } state_t;

endpackage

// File: rtl/seg_digit_decoder.sv
// BCD nibble to seven-segment pattern, with forced blank.
// Non-decimal nibbles render blank.
module seg_digit_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] pattern
);

  // Table lookup, blank wins over the digit.
  always_comb begin
    pattern = SEG_BLANK;
    if (!blank && (bcd <= 4'd9))
      pattern = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/countdown_segment_formatter.sv
// Binary value to eight seven-segment frames via double dabble,
// with leading-zero blanking, decimal points and blink gating.
module countdown_segment_formatter
  import seg_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int VALUE_W   = 27
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  input  logic               blank_zeros,
  input  logic               blink_en,
  input  logic [7:0]         dp_mask,
  output logic [7:0]         seg0,
  output logic [7:0]         seg1,
  output logic [7:0]         seg2,
  output logic [7:0]         seg3,
  output logic [7:0]         seg4,
  output logic [7:0]         seg5,
  output logic [7:0]         seg6,
  output logic [7:0]         seg7,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int XW = (VALUE_W > 27) ? VALUE_W : 27;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [XW-1:0] MAXX = XW'(MAX_DISPLAY);
  localparam logic [CW-1:0] LAST = CW'(VALUE_W - 1);
  localparam logic [BW-1:0] WRAP = BW'(BLINK_DIV - 1);

  state_t             state;
  logic [VALUE_W-1:0] bin;
  logic [31:0]        bcd;
  logic [CW-1:0]      iter;
  logic               bz_r;
  logic               blink_r;
  logic [7:0]         dp_r;
  logic [7:0]         pat [8];
  logic [BW-1:0]      bcnt;
  logic               phase;

  logic [XW-1:0]      vx;
  logic               sat;
  logic [VALUE_W-1:0] vsat;
  logic [31:0]        adj;
  logic [3:0]         dig [8];
  logic [7:0]         lz;
  logic [7:0]         dec [8];
  logic [7:0]         nxt [8];
  logic               gate;

  assign vx   = XW'(value);
  assign sat  = vx > MAXX;
  assign vsat = sat ? VALUE_W'(MAXX) : value;

  // Double-dabble correction: +3 on every nibble >= 5.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 8; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // seg0 is the most significant nibble.
  for (genvar g = 0; g < 8; g++) begin : g_dig
    assign dig[g] = bcd[31-4*g -: 4];

    seg_digit_decoder u_dec (
      .bcd     (dig[g]),
      .blank   (lz[g]),
      .pattern (dec[g])
    );
  end

  // Blank zeros left of the first nonzero digit; seg7 always shows.
  always_comb begin
    logic run;
    run = bz_r;
    lz  = '0;
    for (int i = 0; i < 7; i++) begin
      run   = run && (dig[i] == 4'd0);
      lz[i] = run;
    end
  end

  // Decimal points are ORed in after blanking.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nxt[i] = dec[i];
      nxt[i][SEG_DP] = dec[i][SEG_DP] | dp_r[i];
    end
  end

  // Control FSM with capture, iteration and encode datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      bz_r     <= 1'b0;
      blink_r  <= 1'b0;
      dp_r     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 8; i++)
        pat[i] <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            bin      <= vsat;
            overflow <= sat;
            bz_r     <= blank_zeros;
            blink_r  <= blink_en;
            dp_r     <= dp_mask;
            bcd      <= '0;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd  <= {adj[30:0], bin[VALUE_W-1]};
          bin  <= {bin[VALUE_W-2:0], 1'b0};
          iter <= iter + 1'b1;
          if (iter == LAST)
            state <= ENCODE;
        end
        ENCODE: begin
          for (int i = 0; i < 8; i++)
            pat[i] <= nxt[i];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running blink divider, independent of load.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == WRAP) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign gate = blink_r & phase;

  assign seg0 = gate ? SEG_BLANK : pat[0];
  assign seg1 = gate ? SEG_BLANK : pat[1];
  assign seg2 = gate ? SEG_BLANK : pat[2];
  assign seg3 = gate ? SEG_BLANK : pat[3];
  assign seg4 = gate ? SEG_BLANK : pat[4];
  assign seg5 = gate ? SEG_BLANK : pat[5];
  assign seg6 = gate ? SEG_BLANK : pat[6];
  assign seg7 = gate ? SEG_BLANK : pat[7];

endmodule

// File: tb/tb_countdown_segment_formatter.sv
// Scoreboard bench for countdown_segment_formatter.
// Short blink divider so blink phases are observable.
module tb_countdown_segment_formatter;

  localparam int VW  = 27;
  localparam int BD  = 4;
  localparam int LAT = VW + 1;

  typedef struct {
    logic [63:0] segs;
    logic        ovf;
    logic        blink;
    int          t;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [VW-1:0] value = '0;
  logic          blank_zeros = 1'b0;
  logic          blink_en = 1'b0;
  logic [7:0]    dp_mask = '0;
  logic [7:0]    seg0, seg1, seg2, seg3;
  logic [7:0]    seg4, seg5, seg6, seg7;
  logic          busy, done, overflow;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   donecnt = 0;
  int   mc = 0;
  logic mph = 1'b0;
  exp_t sb [$];

  countdown_segment_formatter #(
    .BLINK_DIV (BD),
    .VALUE_W   (VW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .blank_zeros (blank_zeros),
    .blink_en    (blink_en),
    .dp_mask     (dp_mask),
    .seg0        (seg0),
    .seg1        (seg1),
    .seg2        (seg2),
    .seg3        (seg3),
    .seg4        (seg4),
    .seg5        (seg5),
    .seg6        (seg6),
    .seg7        (seg7),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent model of the blink phase.
  always @(posedge clk) begin
    if (reset) begin
      mc  <= 0;
      mph <= 1'b0;
    end else if (mc == BD - 1) begin
      mc  <= 0;
      mph <= ~mph;
    end else begin
      mc <= mc + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [63:0] frame();
    return {seg0, seg1, seg2, seg3,
            seg4, seg5, seg6, seg7};
  endfunction

  // Monitor: pop one expected frame per done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      logic [63:0] want;
      donecnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=%h", frame());
      end else begin
        e = sb.pop_front();
        want = (e.blink && mph) ? 64'd0 : e.segs;
        chk("frame", frame(), want);
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("latency", 64'(cyc), 64'(e.t + LAT));
      end
    end
  end

  task automatic issue(input logic [VW-1:0] v,
                       input logic bz,
                       input logic be,
                       input logic [7:0] dp,
                       input logic [63:0] segs,
                       input logic ovf);
    exp_t e;
    @(negedge clk);
    value       = v;
    blank_zeros = bz;
    blink_en    = be;
    dp_mask     = dp;
    load        = 1'b1;
    e.segs  = segs;
    e.ovf   = ovf;
    e.blink = be;
    e.t     = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while (donecnt == n0 && k < LAT + 10) begin
      @(negedge clk);
      k++;
    end
    if (donecnt == n0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 want=1");
    end
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_1cyc", 64'(done), 64'd0);
  endtask

  task automatic run(input logic [VW-1:0] v,
                     input logic bz,
                     input logic be,
                     input logic [7:0] dp,
                     input logic [63:0] segs,
                     input logic ovf);
    int n0;
    n0 = donecnt;
    issue(v, bz, be, dp, segs, ovf);
    wait_done(n0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_segs", frame(), 64'd0);
    chk("reset_flags", {61'd0, busy, done, overflow}, 64'd0);

    run(12_345_678, 1'b0, 1'b0, 8'h00,
        64'h60DAF266_B6BEE0FE, 1'b0);
    run(42, 1'b1, 1'b0, 8'h40,
        64'h00000000_000067DA, 1'b0);
    run(42, 1'b1, 1'b0, 8'h02,
        64'h00010000_000066DA, 1'b0);
    run(0, 1'b1, 1'b0, 8'h00,
        64'h00000000_000000FC, 1'b0);
    run(123_456_789, 1'b0, 1'b0, 8'h00,
        64'hF6F6F6F6_F6F6F6F6, 1'b1);
    run(5, 1'b0, 1'b0, 8'h00,
        64'hFCFCFCFC_FCFCFCB6, 1'b0);
    run(99_999_999, 1'b1, 1'b0, 8'h00,
        64'hF6F6F6F6_F6F6F6F6, 1'b0);

    run(8, 1'b1, 1'b1, 8'h00,
        64'h00000000_000000FE, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("blink_seg7", 64'(seg7),
          mph ? 64'h00 : 64'hFE);
    end

    run(8, 1'b1, 1'b0, 8'h00,
        64'h00000000_000000FE, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("steady_seg7", 64'(seg7), 64'hFE);
    end

    n0 = donecnt;
    issue(99, 1'b1, 1'b0, 8'h00,
          64'h00000000_0000F6F6, 1'b0);
    repeat (3) @(negedge clk);
    value = 11;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_done(n0);
    repeat (LAT + 4) @(negedge clk);
    chk("one_done", 64'(donecnt - n0), 64'd1);
    chk("still_99", frame(), 64'h00000000_0000F6F6);

    n0 = donecnt;
    @(negedge clk);
    value       = 77;
    blank_zeros = 1'b0;
    load        = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_segs", frame(), 64'd0);
    chk("abort_flags", {61'd0, busy, done, overflow}, 64'd0);
    repeat (LAT + 6) @(negedge clk);
    chk("abort_no_done", 64'(donecnt - n0), 64'd0);

    run(3, 1'b0, 1'b0, 8'h00,
        64'hFCFCFCFC_FCFCFCF2, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
